// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Purpose  : Sequences an SB_PLL40_CORE bring-up from the reference clock.
//            Pulses the PLL RESETB, waits for a filtered LOCK, holds the
//            PLL-domain reset for a release delay, then runs. Timeouts trigger
//            a retry. Loss of lock while running re-runs the whole sequence.
//            Runs on the reference clock, so it keeps working while the PLL
//            is unlocked.
// Ports    : clk          - reference clock (same net as PLL REFERENCECLK)
//            rst          - synchronous active-high reset
//            pll_lock     - PLL LOCK, asynchronous, synchronized here
//            restart_req  - single-cycle request to re-run the sequence
//            pll_resetb   - PLL RESETB, active low
//            sys_rst      - active-high reset for the PLL-output domain
//            pll_ok       - high only while running
//            retry_count  - timeout retries since rst, saturates at 15
//            fault        - retry limit exhausted
// Options  : `define PLL_SEQ_RETRY_LIMIT_EN adds the FAULT state, entered
//            after MAX_RETRIES consecutive failed attempts. Without it,
//            retries continue forever and fault is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
  parameter int RESET_PULSE   = 16,
  parameter int LOCK_STABLE   = 64,
  parameter int LOCK_TIMEOUT  = 16000,
  parameter int RELEASE_DELAY = 256,
  parameter int LOSS_FILTER   = 4,
  parameter int MAX_RETRIES   = 7,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart_req,
  output logic       pll_resetb,
  output logic       sys_rst,
  output logic       pll_ok,
  output logic [3:0] retry_count,
  output logic       fault
);

  // State encoding
  localparam logic [2:0] c_ST_PLL_RST   = 3'd0;
  localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] c_ST_RELEASE   = 3'd2;
  localparam logic [2:0] c_ST_RUN       = 3'd3;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  localparam logic [2:0] c_ST_FAULT     = 3'd4;
`endif

  // Terminal compares: counters start at 0 on state entry, so the last
  // cycle of an N-cycle interval sees the counter at N-1.
  localparam logic [CNT_W-1:0] c_RST_LAST     = CNT_W'(RESET_PULSE - 1);
  localparam logic [CNT_W-1:0] c_STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_RELEASE_LAST = CNT_W'(RELEASE_DELAY - 1);
  localparam logic [CNT_W-1:0] c_LOSS_LAST    = CNT_W'(LOSS_FILTER - 1);
  // Fail counter saturates at the retry limit so it can never wrap.
  localparam logic [CNT_W-1:0] c_FAIL_SAT     = CNT_W'(MAX_RETRIES);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  localparam logic [CNT_W-1:0] c_FAIL_LAST    = CNT_W'(MAX_RETRIES - 1);
`endif

  logic             sync1_q;
  logic             lock_s_q;
  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] filt_q;
  logic [CNT_W-1:0] fail_q;
  logic [3:0]       retry_q;
  logic             pll_resetb_q;
  logic             sys_rst_q;
  logic             pll_ok_q;
  logic             pll_resetb_d;
  logic             sys_rst_d;
  logic             pll_ok_d;
  logic             timeout_w;
  logic             restart_w;
  logic             state_chg_w;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  logic             fault_q;
  logic             fault_d;
`endif

  // A restart during PLL_RST is ignored so the pulse length stays intact.
  assign restart_w   = restart_req && (state_q != c_ST_PLL_RST);
  assign state_chg_w = (state_d != state_q);

  // 2-flop synchronizer for the asynchronous LOCK output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  // State and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= c_ST_PLL_RST;
      pll_resetb_q <= 1'b0;
      sys_rst_q    <= 1'b1;
      pll_ok_q     <= 1'b0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pll_resetb_q <= pll_resetb_d;
      sys_rst_q    <= sys_rst_d;
      pll_ok_q     <= pll_ok_d;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
      fault_q      <= fault_d;
`endif
    end
  end

  // Next-state logic. restart_req overrides every other transition.
  always_comb begin
    state_d   = state_q;
    timeout_w = 1'b0;
    if (restart_w) begin
      state_d = c_ST_PLL_RST;
    end else begin
      case (state_q)
        c_ST_PLL_RST: begin
          if (phase_q == c_RST_LAST) state_d = c_ST_WAIT_LOCK;
        end
        c_ST_WAIT_LOCK: begin
          // Lock acceptance is checked first so it wins over a
          // coincident timeout.
          if (lock_s_q && (filt_q == c_STABLE_LAST)) begin
            state_d = c_ST_RELEASE;
          end else if (phase_q == c_TIMEOUT_LAST) begin
            timeout_w = 1'b1;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
            state_d   = (fail_q >= c_FAIL_LAST) ? c_ST_FAULT : c_ST_PLL_RST;
`else
            state_d   = c_ST_PLL_RST;
`endif
          end
        end
        c_ST_RELEASE: begin
          if (!lock_s_q) begin
            state_d = c_ST_WAIT_LOCK;
          end else if (phase_q == c_RELEASE_LAST) begin
            state_d = c_ST_RUN;
          end
        end
        c_ST_RUN: begin
          if (!lock_s_q && (filt_q == c_LOSS_LAST)) state_d = c_ST_PLL_RST;
        end
`ifdef PLL_SEQ_RETRY_LIMIT_EN
        c_ST_FAULT: begin
          state_d = c_ST_FAULT;
        end
`endif
        default: begin
          state_d = c_ST_PLL_RST;
        end
      endcase
    end
  end

  // Output decode from the next state, so the registered outputs change on
  // the same edge as the state itself.
  always_comb begin
    pll_resetb_d = 1'b0;
    sys_rst_d    = 1'b1;
    pll_ok_d     = 1'b0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    fault_d      = 1'b0;
`endif
    case (state_d)
      c_ST_WAIT_LOCK, c_ST_RELEASE: begin
        pll_resetb_d = 1'b1;
      end
      c_ST_RUN: begin
        pll_resetb_d = 1'b1;
        sys_rst_d    = 1'b0;
        pll_ok_d     = 1'b1;
      end
`ifdef PLL_SEQ_RETRY_LIMIT_EN
      c_ST_FAULT: begin
        fault_d = 1'b1;
      end
`endif
      default: begin
        pll_resetb_d = 1'b0;
      end
    endcase
  end

  // Phase counter, stable/loss filter, fail counter and retry counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      filt_q  <= '0;
      fail_q  <= '0;
      retry_q <= '0;
    end else begin
      if (state_chg_w) begin
        phase_q <= '0;
        filt_q  <= '0;
      end else begin
        case (state_q)
          c_ST_PLL_RST, c_ST_WAIT_LOCK, c_ST_RELEASE: phase_q <= phase_q + 1'b1;
          default:                                    phase_q <= phase_q;
        endcase
        // WAIT_LOCK counts consecutive lock-high cycles, RUN counts
        // consecutive lock-low cycles.
        case (state_q)
          c_ST_WAIT_LOCK: filt_q <= lock_s_q ? filt_q + 1'b1 : '0;
          c_ST_RUN:       filt_q <= lock_s_q ? '0 : filt_q + 1'b1;
          default:        filt_q <= '0;
        endcase
      end

      if (restart_w || (state_chg_w && (state_d == c_ST_RUN))) begin
        fail_q <= '0;
      end else if (timeout_w && (fail_q != c_FAIL_SAT)) begin
        fail_q <= fail_q + 1'b1;
      end

      if (timeout_w && (retry_q != 4'hF)) begin
        retry_q <= retry_q + 4'd1;
      end
    end
  end

  assign pll_resetb  = pll_resetb_q;
  assign sys_rst     = sys_rst_q;
  assign pll_ok      = pll_ok_q;
  assign retry_count = retry_q;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  assign fault       = fault_q;
`else
  assign fault       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Purpose  : Self-checking bench for pll_reset_sequencer. A cycle-level
//            reference model built from phase durations and lock run-lengths
//            checks every output after every clock edge. A vector table and
//            hand-written sequences check bring-up timing, retries, glitch
//            filtering, restart priority and (with PLL_SEQ_RETRY_LIMIT_EN)
//            the FAULT state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

  localparam int RP = 4;
  localparam int LS = 8;
  localparam int LT = 50;
  localparam int RD = 10;
  localparam int LF = 3;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       restart_req = 1'b0;
  logic       pll_resetb;
  logic       sys_rst;
  logic       pll_ok;
  logic [3:0] retry_count;
  logic       fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RESET_PULSE  (RP),
    .LOCK_STABLE  (LS),
    .LOCK_TIMEOUT (LT),
    .RELEASE_DELAY(RD),
    .LOSS_FILTER  (LF),
    .MAX_RETRIES  (MR),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .restart_req(restart_req),
    .pll_resetb (pll_resetb),
    .sys_rst    (sys_rst),
    .pll_ok     (pll_ok),
    .retry_count(retry_count),
    .fault      (fault)
  );

  // ---------------- reference model ----------------
  // Phases: 0 pulse, 1 waiting for lock, 2 release delay, 3 running, 4 fault.
  int m_phase;
  int m_t;       // cycles already spent in the current phase
  int m_hi;      // current run of synchronized-lock-high samples
  int m_lo;      // current run of synchronized-lock-low samples
  int m_retry;
  int m_fails;
  bit m_hist[$]; // raw lock samples still inside the 2-cycle synchronizer

  function automatic void model_reset();
    m_phase = 0; m_t = 0; m_hi = 0; m_lo = 0; m_retry = 0; m_fails = 0;
    m_hist.delete();
    m_hist.push_back(1'b0);
    m_hist.push_back(1'b0);
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_edge(bit r, bit lk, bit rq);
    bit ls;
    int t;
    int nxt;
    if (r) begin
      model_reset();
      return;
    end
    ls = m_hist[0];
    void'(m_hist.pop_front());
    m_hist.push_back(lk);
    m_hi = ls ? m_hi + 1 : 0;
    m_lo = ls ? 0 : m_lo + 1;
    t   = m_t + 1;
    nxt = m_phase;
    if (rq && m_phase != 0) begin
      nxt     = 0;
      m_fails = 0;
    end else begin
      case (m_phase)
        0: if (t >= RP) nxt = 1;
        1: begin
          if (imin(m_hi, t) >= LS) nxt = 2;
          else if (t >= LT) begin
            if (m_retry < 15) m_retry++;
            m_fails++;
            nxt = 0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
            if (m_fails >= MR) nxt = 4;
`endif
          end
        end
        2: begin
          if (!ls) nxt = 1;
          else if (t >= RD) begin
            nxt     = 3;
            m_fails = 0;
          end
        end
        3: if (imin(m_lo, t) >= LF) nxt = 0;
        default: ;
      endcase
    end
    m_t     = (nxt == m_phase) ? t : 0;
    m_phase = nxt;
  endfunction

  task automatic check_model();
    logic       e_rb, e_sr, e_ok, e_f;
    logic [3:0] e_rc;
    e_rb = !(m_phase == 0 || m_phase == 4);
    e_sr = (m_phase != 3);
    e_ok = (m_phase == 3);
    e_f  = (m_phase == 4);
    e_rc = 4'(m_retry);
    checks++;
    if (pll_resetb !== e_rb || sys_rst !== e_sr || pll_ok !== e_ok ||
        retry_count !== e_rc || fault !== e_f) begin
      failures++;
      $display("FAIL model t=%0t got resetb=%b sys_rst=%b ok=%b retry=%0d fault=%b exp resetb=%b sys_rst=%b ok=%b retry=%0d fault=%b",
               $time, pll_resetb, sys_rst, pll_ok, retry_count, fault,
               e_rb, e_sr, e_ok, e_rc, e_f);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: model sees the same inputs the DUT samples.
  task automatic step();
    @(posedge clk);
    model_edge(rst, pll_lock, restart_req);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1; restart_req = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic steps_until_ok(output int n);
    n = 0;
    while (pll_ok !== 1'b1 && n < 500) begin step(); n++; end
  endtask

  task automatic measure_pulse(output int len);
    int n;
    n = 0;
    while (pll_resetb !== 1'b0 && n < 200) begin step(); n++; end
    len = 0;
    while (pll_resetb === 1'b0 && len < 200) begin step(); len++; end
  endtask

  typedef struct {
    int lock_delay;  // cycles after pll_resetb rises before pll_lock rises
    int exp_pulse;
    int exp_to_run;  // cycles from pll_lock rise to pll_ok
    int exp_retry;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   len, n, r0;
    int   remaining;

    vecs[0] = '{lock_delay: 10, exp_pulse: 4, exp_to_run: 20, exp_retry: 0};
    vecs[1] = '{lock_delay: 0,  exp_pulse: 4, exp_to_run: 20, exp_retry: 0};
    vecs[2] = '{lock_delay: 40, exp_pulse: 4, exp_to_run: 20, exp_retry: 0};
    vecs[3] = '{lock_delay: 41, exp_pulse: 4, exp_to_run: 31, exp_retry: 1};

    model_reset();
    do_reset();
    check_int("reset_resetb", int'(pll_resetb), 0);
    check_int("reset_sys_rst", int'(sys_rst), 1);
    check_int("reset_pll_ok", int'(pll_ok), 0);
    check_int("reset_retry", int'(retry_count), 0);
    check_int("reset_fault", int'(fault), 0);

    // Table-driven bring-up timing
    for (int i = 0; i < 4; i++) begin
      pll_lock = 1'b0;
      do_reset();
      measure_pulse(len);
      check_int("tbl_pulse", len, vecs[i].exp_pulse);
      repeat (vecs[i].lock_delay) step();
      pll_lock = 1'b1;
      steps_until_ok(n);
      check_int("tbl_to_run", n, vecs[i].exp_to_run);
      check_int("tbl_retry", int'(retry_count), vecs[i].exp_retry);
    end

    // Glitch filtering in RUN
    r0 = int'(retry_count);
    pll_lock = 1'b0; step(); step(); pll_lock = 1'b1;
    repeat (10) step();
    check_int("glitch2_ok", int'(pll_ok), 1);
    pll_lock = 1'b0;
    n = 0;
    while (pll_ok === 1'b1 && n < 20) begin step(); n++; end
    check_int("loss_latency", n, 5);
    check_int("loss_resetb", int'(pll_resetb), 0);
    check_int("loss_sys_rst", int'(sys_rst), 1);
    check_int("loss_retry", int'(retry_count), r0);
    pll_lock = 1'b1;
    steps_until_ok(n);
    check_int("loss_rerun", n, 22);

    // Lock drop during RELEASE
    pll_lock = 1'b0;
    do_reset();
    measure_pulse(len);
    pll_lock = 1'b1;
    repeat (14) step();
    pll_lock = 1'b0; step(); pll_lock = 1'b1;
    steps_until_ok(n);
    check_int("rel_drop_to_run", n, 20);
    check_int("rel_drop_retry", int'(retry_count), 0);

    // restart_req coincident with loss terminal count
    r0 = int'(retry_count);
    pll_lock = 1'b0;
    repeat (4) step();
    restart_req = 1'b1; step(); restart_req = 1'b0;
    check_int("rq_loss_resetb", int'(pll_resetb), 0);
    measure_pulse(len);
    check_int("rq_loss_pulse", len, 4);
    check_int("rq_loss_retry", int'(retry_count), r0);

    // restart_req during PLL_RST does not stretch the pulse
    pll_lock = 1'b1;
    steps_until_ok(n);
    restart_req = 1'b1; step(); restart_req = 1'b0;
    check_int("rq_run_resetb", int'(pll_resetb), 0);
    len = 0;
    step(); len++;
    restart_req = 1'b1; step(); len++; restart_req = 1'b0;
    while (pll_resetb === 1'b0 && len < 20) begin step(); len++; end
    check_int("rq_in_rst_pulse", len, 4);

`ifndef PLL_SEQ_RETRY_LIMIT_EN
    // Timeout retries and saturation
    pll_lock = 1'b0;
    do_reset();
    measure_pulse(len);
    for (int r = 1; r <= 17; r++) begin
      n = 0;
      while (pll_resetb === 1'b1 && n < 100) begin step(); n++; end
      check_int("timeout_len", n, LT);
      check_int("retry_step", int'(retry_count), (r < 15) ? r : 15);
      measure_pulse(len);
      check_int("retry_pulse", len, 4);
    end
`else
    // Retry limit and FAULT
    pll_lock = 1'b0;
    do_reset();
    measure_pulse(len);
    n = 0;
    while (fault !== 1'b1 && n < 300) begin step(); n++; end
    check_int("fault_latency", n, 2 * LT + RP);
    repeat (20) step();
    check_int("fault_held", int'(fault), 1);
    check_int("fault_resetb", int'(pll_resetb), 0);
    restart_req = 1'b1; step(); restart_req = 1'b0;
    check_int("fault_clear", int'(fault), 0);
    measure_pulse(len);
    check_int("fault_pulse", len, 4);
    pll_lock = 1'b1;
    steps_until_ok(n);
    check_int("fault_to_run", int'(pll_ok), 1);
`endif

    // rst while running
    pll_lock = 1'b1;
    steps_until_ok(n);
    rst = 1'b1; step(); rst = 1'b0;
    check_int("midrst_resetb", int'(pll_resetb), 0);
    check_int("midrst_sys_rst", int'(sys_rst), 1);
    check_int("midrst_ok", int'(pll_ok), 0);
    check_int("midrst_retry", int'(retry_count), 0);

    // Randomized lock behaviour against the model
    remaining = 0;
    for (int c = 0; c < 4000; c++) begin
      if (remaining == 0) begin
        if (pll_lock) begin
          pll_lock  = 1'b0;
          remaining = ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 120))
                                                  : int'($urandom_range(1, 5));
        end else begin
          pll_lock  = 1'b1;
          remaining = int'($urandom_range(10, 150));
        end
      end
      remaining--;
      restart_req = ($urandom_range(0, 149) == 0);
      rst         = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;
    restart_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controls the SB_PLL40_CORE wrapper: drives its RESETB, filters its LOCK output, and generates the system reset for the PLL-clocked domain.
- Runs in the reference-clock domain (16 MHz), so it keeps running while the PLL is unlocked.
- Retries PLL acquisition on timeout, re-sequences on loss of lock, and reports status.

Parameters:
- RESET_PULSE, 16: cycles pll_resetb is held low per attempt (≥1).
- LOCK_STABLE, 64: consecutive synced-lock-high cycles needed to accept lock (≥1, < LOCK_TIMEOUT).
- LOCK_TIMEOUT, 16000: cycles allowed in WAIT_LOCK before a retry (1 ms at 16 MHz).
- RELEASE_DELAY, 256: cycles sys_rst stays asserted after lock is accepted (≥1).
- LOSS_FILTER, 4: consecutive synced-lock-low cycles in RUN that count as loss of lock (≥1).
- MAX_RETRIES, 7: consecutive failed attempts before FAULT (optional feature only).
- CNT_W, 16: counter width; every cycle parameter must fit in CNT_W.

Ports:
- clk, input, 1: reference clock; the same net that feeds the PLL REFERENCECLK.
- rst, input, 1: synchronous, active-high reset.
- pll_lock, input, 1: PLL LOCK output. Asynchronous; synchronized internally.
- restart_req, input, 1: single-cycle request to re-run the full sequence.
- pll_resetb, output, 1: drives PLL RESETB (active low).
- sys_rst, output, 1: active-high reset for the PLL-output domain. The consumer must synchronize deassertion.
- pll_ok, output, 1: high only in RUN.
- retry_count, output, 4: total timeout retries since rst; saturates at 15.
- fault, output, 1: retry limit exhausted (optional feature only).

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst). All outputs are registered Moore outputs of the state.
- pll_lock passes through a 2-flop synchronizer; lock_s is pll_lock delayed 2 cycles.
- Reset values: state=PLL_RST, pll_resetb=0, sys_rst=1, pll_ok=0, retry_count=0, fault=0, all counters=0.
- One phase counter, cleared on every state entry. One stable/loss filter counter. One consecutive-fail counter.
- PLL_RST:
  - pll_resetb=0, sys_rst=1.
  - After exactly RESET_PULSE cycles in this state -> WAIT_LOCK.
- WAIT_LOCK:
  - pll_resetb=1, sys_rst=1.
  - Stable counter increments while lock_s=1 and clears when lock_s=0.
  - Stable counter reaches LOCK_STABLE -> RELEASE.
  - Otherwise, phase counter reaches LOCK_TIMEOUT -> PLL_RST, retry_count+1 (saturating), fail counter+1.
  - If both conditions occur in the same cycle, lock wins (-> RELEASE).
- RELEASE:
  - sys_rst=1.
  - Any cycle with lock_s=0 -> WAIT_LOCK. This is not a retry; the timeout phase restarts.
  - After RELEASE_DELAY cycles -> RUN. sys_rst deasserts on the cycle RUN is entered.
- RUN:
  - sys_rst=0, pll_ok=1. Fail counter is cleared on entry.
  - Loss counter counts consecutive lock_s=0 cycles; it resets to 0 on any lock_s=1.
  - Loss counter reaches LOSS_FILTER -> PLL_RST. sys_rst=1 and pll_ok=0 on the next cycle. retry_count is not incremented.
  - Glitches shorter than LOSS_FILTER cycles are ignored.
- restart_req:
  - Has highest priority; it overrides every other transition in the same cycle.
  - In any state other than PLL_RST -> PLL_RST next cycle. The fail counter is cleared; retry_count is unchanged.
  - In PLL_RST it is ignored; the pulse timing is not restarted.
- rst asserted mid-sequence: returns to reset values on the next edge, including in RUN.
- Counters never wrap. Phase and filter counters stop at their terminal compare because the state changes.

Optional Feature:
- Macro: PLL_SEQ_RETRY_LIMIT_EN.
- Defined:
  - When a timeout makes the fail counter reach MAX_RETRIES, the next state is FAULT instead of PLL_RST.
  - FAULT: pll_resetb=0, sys_rst=1, pll_ok=0, fault=1.
  - FAULT is left only via rst, or via restart_req -> PLL_RST with fault cleared.
- Undefined:
  - No FAULT state; retries continue indefinitely.
  - fault is constant 0 and MAX_RETRIES is unused.

Test Plan (RESET_PULSE=4, LOCK_STABLE=8, LOCK_TIMEOUT=50, RELEASE_DELAY=10, LOSS_FILTER=3, MAX_RETRIES=2):
- Nominal bring-up: release rst, raise pll_lock 10 cycles after pll_resetb rises -> pll_resetb low for exactly 4 cycles after rst; sys_rst falls and pll_ok rises 2+8+10 cycles after the pll_lock rise; retry_count=0.
- Timeout retry: hold pll_lock=0 -> pll_resetb re-pulses low for 4 cycles after each 50-cycle WAIT_LOCK; retry_count steps 1, 2, ... and saturates at 15 (macro undefined).
- Lock glitch filtering in RUN: drop pll_lock for 2 cycles -> no change. Drop it for 3 cycles -> sys_rst=1, pll_ok=0, pll_resetb=0 exactly 2+3 cycles after the drop, then the full sequence reruns; retry_count is unchanged.
- Drop in RELEASE: pulse pll_lock low for 1 cycle at RELEASE cycle 5 -> back to WAIT_LOCK, sys_rst stays 1, no retry_count increment, RUN reached after a fresh 8+10 cycles.
- restart_req in RUN coincident with a loss-filter terminal count -> a single PLL_RST entry (4-cycle pulse). restart_req during PLL_RST -> pulse length is still 4.
- Macro defined, pll_lock=0: after 2 timeouts -> fault=1, pll_resetb held 0. restart_req -> fault=0 and a 4-cycle PLL_RST pulse. Raise pll_lock -> RUN reached.
